// File: rtl/simon_cipher.sv
// Iterative Simon block cipher: one round per clock, key schedule computed on the fly.
// Decryption first runs the key schedule forward to capture the last NKW round keys,
// then unrolls it backwards while applying inverse rounds.
module simon_cipher #(
    parameter int unsigned WW       = 16,
    parameter int unsigned NKW      = 4,
    parameter bit          DATA_RST = 1'b0
) (
    input  logic              clk,
    input  logic              arst_n,
    output logic              active_o,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              mode_i,
    input  logic [2*WW-1:0]   pt_i,
    input  logic [NKW*WW-1:0] key_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              mode_o,
    output logic [2*WW-1:0]   ct_o
);

    function automatic int unsigned rounds_f(int unsigned w, int unsigned m);
        if (w == 16 && m == 4) return 32;
        if (w == 24 && m == 3) return 36;
        if (w == 24 && m == 4) return 36;
        if (w == 32 && m == 3) return 42;
        if (w == 32 && m == 4) return 44;
        if (w == 48 && m == 2) return 52;
        if (w == 48 && m == 3) return 54;
        if (w == 64 && m == 2) return 68;
        if (w == 64 && m == 3) return 69;
        if (w == 64 && m == 4) return 72;
        return 0;
    endfunction

    function automatic int unsigned zsel_f(int unsigned w, int unsigned m);
        if (w == 24 && m == 4) return 1;
        if (w == 32 && m == 3) return 2;
        if (w == 32 && m == 4) return 3;
        if (w == 48 && m == 2) return 2;
        if (w == 48 && m == 3) return 3;
        if (w == 64 && m == 2) return 2;
        if (w == 64 && m == 3) return 3;
        if (w == 64 && m == 4) return 4;
        return 0;
    endfunction

    // Sequences written in published order: leftmost character is z[0].
    function automatic logic [61:0] zseq_f(int unsigned s);
        case (s)
            1: return 62'b10001110111110010011000010110101000111011111001001100001011010;
            2: return 62'b10101111011100000011010010011000101000010001111110010110110011;
            3: return 62'b11011011101011000110010111100000010010001010011100110100001111;
            4: return 62'b11010001111001101011011000100000010111000011001010010011101111;
            default: return 62'b11111010001001010110000111001101111101000100101011000011100110;
        endcase
    endfunction

    // Bit-reverse so that z[j] is simply bit j of the constant.
    function automatic logic [61:0] zrev_f(logic [61:0] z);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) r[i] = z[61-i];
        return r;
    endfunction

    localparam int unsigned T       = rounds_f(WW, NKW);
    localparam logic [61:0] ZBits   = zrev_f(zseq_f(zsel_f(WW, NKW)));
    localparam logic [6:0]  LastRnd = 7'(T - 1);
    localparam logic [6:0]  LastKey = 7'(T - NKW - 1);
    localparam logic [WW-1:0] C3    = WW'(3);

    if (T == 0) begin : g_illegal
        $error("simon_cipher: illegal WW/NKW combination");
    end

    function automatic logic [WW-1:0] rotl(logic [WW-1:0] a, int unsigned j);
        return (a << j) | (a >> (WW - j));
    endfunction

    function automatic logic [WW-1:0] rotr(logic [WW-1:0] a, int unsigned j);
        return (a >> j) | (a << (WW - j));
    endfunction

    function automatic logic [WW-1:0] f_rnd(logic [WW-1:0] a);
        return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
    endfunction

    // Shared key-schedule mixing term; hi = k(j+m-1), lo = k(j+1).
    function automatic logic [WW-1:0] ks_tmp(logic [WW-1:0] hi, logic [WW-1:0] lo);
        logic [WW-1:0] t;
        t = rotr(hi, 3);
        if (NKW == 4) t = t ^ lo;
        t = t ^ rotr(t, 1);
        return t;
    endfunction

    typedef enum logic [2:0] {
        StIdle, StEncRun, StKeyExp, StDecLoad, StDecRun, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [5:0]    zi_q, zi_d;
    logic          mode_q, mode_d;

    logic [WW-1:0]   x_q, x_d, y_q, y_d;
    logic [WW-1:0]   kw_q [NKW];
    logic [WW-1:0]   kw_d [NKW];
    logic [WW-1:0]   ks_q [NKW];
    logic [WW-1:0]   ks_d [NKW];
    logic [2*WW-1:0] ct_q, ct_d;

    logic [5:0]    zi_inc, zi_dec;
    logic [WW-1:0] k_fwd, k_inv;
    logic [WW-1:0] enc_x, dec_y;

    // zi_q tracks the z index of the next forward step; inverse steps use the one before it.
    assign zi_inc = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
    assign zi_dec = (zi_q == 6'd0) ? 6'd61 : zi_q - 6'd1;

    assign k_fwd = ~kw_q[0] ^ ks_tmp(kw_q[NKW-1], kw_q[1])
                   ^ {{(WW-1){1'b0}}, ZBits[zi_q]} ^ C3;
    assign k_inv = ~kw_q[NKW-1] ^ ks_tmp(kw_q[NKW-2], kw_q[0])
                   ^ {{(WW-1){1'b0}}, ZBits[zi_dec]} ^ C3;

    assign enc_x = y_q ^ f_rnd(x_q) ^ kw_q[0];
    assign dec_y = x_q ^ f_rnd(y_q) ^ kw_q[NKW-1];

    assign active_o = (state_q != StIdle);
    assign ready_o  = (state_q == StIdle);
    assign valid_o  = (state_q == StDone);
    assign mode_o   = mode_q;
    assign ct_o     = ct_q;

    // Next-state logic for control and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zi_d    = zi_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        kw_d    = kw_q;
        ks_d    = ks_q;
        ct_d    = ct_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    x_d    = pt_i[2*WW-1:WW];
                    y_d    = pt_i[WW-1:0];
                    for (int j = 0; j < NKW; j++) kw_d[j] = key_i[j*WW +: WW];
                    mode_d = mode_i;
                    cnt_d  = '0;
                    zi_d   = '0;
                    state_d = mode_i ? StKeyExp : StEncRun;
                end
            end
            StEncRun: begin
                x_d = enc_x;
                y_d = x_q;
                for (int j = 0; j < NKW - 1; j++) kw_d[j] = kw_q[j+1];
                kw_d[NKW-1] = k_fwd;
                zi_d  = zi_inc;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LastRnd) begin
                    ct_d    = {enc_x, x_q};
                    state_d = StDone;
                end
            end
            StKeyExp: begin
                for (int j = 0; j < NKW - 1; j++) kw_d[j] = kw_q[j+1];
                kw_d[NKW-1] = k_fwd;
                zi_d  = zi_inc;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LastKey) begin
                    ks_d    = kw_d;
                    cnt_d   = '0;
                    state_d = StDecLoad;
                end
            end
            StDecLoad: begin
                kw_d    = ks_q;
                state_d = StDecRun;
            end
            StDecRun: begin
                x_d = y_q;
                y_d = dec_y;
                for (int j = 1; j < NKW; j++) kw_d[j] = kw_q[j-1];
                kw_d[0] = k_inv;
                zi_d  = zi_dec;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LastRnd) begin
                    ct_d    = {y_q, dec_y};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            zi_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zi_q    <= zi_d;
            mode_q  <= mode_d;
        end
    end

    if (DATA_RST) begin : g_data_rst
        // Data registers cleared by reset.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                x_q  <= '0;
                y_q  <= '0;
                kw_q <= '{default: '0};
                ks_q <= '{default: '0};
                ct_q <= '0;
            end else begin
                x_q  <= x_d;
                y_q  <= y_d;
                kw_q <= kw_d;
                ks_q <= ks_d;
                ct_q <= ct_d;
            end
        end
    end else begin : g_data_nrst
        // Data registers without reset.
        always_ff @(posedge clk) begin
            x_q  <= x_d;
            y_q  <= y_d;
            kw_q <= kw_d;
            ks_q <= ks_d;
            ct_q <= ct_d;
        end
    end

    in_stable_a: assert property (@(posedge clk) disable iff (!arst_n)
        (valid_i && !ready_o) |=>
            (valid_i && $stable(pt_i) && $stable(key_i) && $stable(mode_i)));

    out_stable_a: assert property (@(posedge clk) disable iff (!arst_n)
        (valid_o && !ready_i) |=> (valid_o && $stable(ct_o) && $stable(mode_o)));

endmodule

// File: tb/tb_simon_cipher.sv
// Directed bench for simon_cipher: Simon32/64 and Simon64/128 instances, scoreboard-checked.
module tb_simon_cipher;

    localparam int T16 = 32;
    localparam int T32 = 44;
    localparam int D16 = 2 * T16 - 4 + 1;
    localparam int D32 = 2 * T32 - 4 + 1;

    localparam logic [127:0] K16  = 128'h0000000000000000_1918111009080100;
    localparam logic [63:0]  P16  = 64'h00000000_65656877;
    localparam logic [63:0]  C16  = 64'h00000000_c69be9bb;
    localparam logic [127:0] K32  = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  P32  = 64'h656b696c_20646e75;
    localparam logic [63:0]  C32  = 64'h44c8fc20_b9dfa07a;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         valid16, valid32, mode_in, ready_in;
    logic [63:0]  pt;
    logic [127:0] key;

    logic         act16, rdy16, vld16, mo16;
    logic [31:0]  ct16;
    logic         act32, rdy32, vld32, mo32;
    logic [63:0]  ct32;

    typedef struct packed {
        logic [63:0] ct;
        logic        mode;
    } exp_t;

    exp_t sb[$];
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;
    int   w;

    always #5 clk = ~clk;

    simon_cipher #(.WW(16), .NKW(4), .DATA_RST(1'b0)) u_dut16 (
        .clk      (clk),
        .arst_n   (arst_n),
        .active_o (act16),
        .valid_i  (valid16),
        .ready_o  (rdy16),
        .mode_i   (mode_in),
        .pt_i     (pt[31:0]),
        .key_i    (key[63:0]),
        .valid_o  (vld16),
        .ready_i  (ready_in),
        .mode_o   (mo16),
        .ct_o     (ct16)
    );

    simon_cipher #(.WW(32), .NKW(4), .DATA_RST(1'b1)) u_dut32 (
        .clk      (clk),
        .arst_n   (arst_n),
        .active_o (act32),
        .valid_i  (valid32),
        .ready_o  (rdy32),
        .mode_i   (mode_in),
        .pt_i     (pt),
        .key_i    (key),
        .valid_o  (vld32),
        .ready_i  (ready_in),
        .mode_o   (mo32),
        .ct_o     (ct32)
    );

    function automatic logic get_rdy();
        return (sel == 0) ? rdy16 : rdy32;
    endfunction
    function automatic logic get_vld();
        return (sel == 0) ? vld16 : vld32;
    endfunction
    function automatic logic get_act();
        return (sel == 0) ? act16 : act32;
    endfunction
    function automatic logic get_mode();
        return (sel == 0) ? mo16 : mo32;
    endfunction
    function automatic logic [63:0] get_ct();
        return (sel == 0) ? {32'h0, ct16} : ct32;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input int s, input logic m, input logic [63:0] p,
                            input logic [127:0] k, input logic [63:0] e);
        exp_t x;
        @(negedge clk);
        sel     = s;
        mode_in = m;
        pt      = p;
        key     = k;
        if (s == 0) valid16 = 1'b1;
        else        valid32 = 1'b1;
        x.ct   = e;
        x.mode = m;
        sb.push_back(x);
    endtask

    // Waits for ready_o, then lets the handshake edge pass and drops valid.
    task automatic wait_accept(output int waited);
        waited = 0;
        while (!get_rdy() && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!get_rdy()) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        valid16 = 1'b0;
        valid32 = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input int hold);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!get_vld() && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!get_vld()) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, 64'(get_vld()), 64'd1);
            chk({tag, "_hold_ct"}, get_ct(), e.ct);
            chk({tag, "_hold_mode"}, 64'(get_mode()), 64'(e.mode));
            chk({tag, "_hold_rdy"}, 64'(get_rdy()), 64'd0);
            chk({tag, "_hold_act"}, 64'(get_act()), 64'd1);
        end
        @(negedge clk);
        chk({tag, "_ct"}, get_ct(), e.ct);
        chk({tag, "_mode"}, 64'(get_mode()), 64'(e.mode));
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        @(negedge clk);
        chk({tag, "_post_rdy"}, 64'(get_rdy()), 64'd1);
        chk({tag, "_post_act"}, 64'(get_act()), 64'd0);
        chk({tag, "_post_vld"}, 64'(get_vld()), 64'd0);
        chk({tag, "_post_ct"}, get_ct(), e.ct);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n   = 1'b0;
        valid16  = 1'b0;
        valid32  = 1'b0;
        mode_in  = 1'b0;
        ready_in = 1'b0;
        pt       = '0;
        key      = '0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst_rdy", 64'(get_rdy()), 64'd1);
            chk("rst_vld", 64'(get_vld()), 64'd0);
            chk("rst_act", 64'(get_act()), 64'd0);
            chk("rst_mode", 64'(get_mode()), 64'd0);
        end
        chk("rst_ct32", ct32, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Simon32/64 encrypt and decrypt.
        drive_in(0, 1'b0, P16, K16, C16);
        wait_accept(w);
        wait_result("enc16", T16, 0);
        drive_in(0, 1'b1, C16, K16, P16);
        wait_accept(w);
        wait_result("dec16", D16, 0);

        // Simon64/128 encrypt and decrypt.
        drive_in(1, 1'b0, P32, K32, C32);
        wait_accept(w);
        wait_result("enc32", T32, 0);
        drive_in(1, 1'b1, C32, K32, P32);
        wait_accept(w);
        wait_result("dec32", D32, 0);

        // Output backpressure for 10 cycles.
        drive_in(0, 1'b0, P16, K16, C16);
        wait_accept(w);
        wait_result("bp16", T16, 10);

        // Reset in the middle of an encryption.
        @(negedge clk);
        sel     = 0;
        mode_in = 1'b0;
        pt      = P16;
        key     = K16;
        valid16 = 1'b1;
        wait_accept(w);
        repeat (5) @(negedge clk);
        chk("mid_act", 64'(act16), 64'd1);
        chk("mid_vld", 64'(vld16), 64'd0);
        arst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(vld16), 64'd0);
        chk("arst_rdy", 64'(rdy16), 64'd1);
        chk("arst_act", 64'(act16), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        drive_in(0, 1'b0, P16, K16, C16);
        wait_accept(w);
        wait_result("after_rst", T16, 0);

        // Second job held on the input across the DONE state.
        drive_in(0, 1'b0, P16, K16, C16);
        wait_accept(w);
        drive_in(0, 1'b1, C16, K16, P16);
        wait_result("stall_a", T16, 3);
        wait_accept(w);
        chk("stall_accept_wait", 64'(w), 64'd0);
        wait_result("stall_b", D16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_cipher.md
Name: simon_cipher

Overview:
- Iterative NSA Simon block cipher (Beaulieu et al., DAC 2015): one round per clock, with on-the-fly key schedule.
- Supports encryption and decryption behind valid/ready input and output handshakes.
- Contains a round datapath (state words, key window, round function, forward and inverse key schedule) and a control FSM.
- Sits as a standalone crypto accelerator between a producer and a consumer.

Parameters:
- WW, 16, word size n; legal values 16, 24, 32, 48, 64.
- NKW, 4, key words m. Legal pairs: WW16:{4}; WW24/32:{3,4}; WW48:{2,3}; WW64:{2,3,4}. Illegal pairs raise a simulation error.
- DATA_RST, 0, when 1 all data registers (state, key window, decrypt key store, ct_o) reset to 0; when 0 they have no reset.

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- active_o  out  1  high whenever the FSM is not IDLE
- valid_i  in  1  input request
- ready_o  out  1  input accepted when valid_i & ready_o
- mode_i  in  1  0 = encrypt, 1 = decrypt
- pt_i  in  2*WW  [1] = x (upper word), [0] = y
- key_i  in  NKW*WW  [0] = k0, [NKW-1] = k(m-1)
- valid_o  out  1  result valid
- ready_i  in  1  result consumed when valid_o & ready_i
- mode_o  out  1  mode of the job currently held on the output
- ct_o  out  2*WW  result; [1] = x, [0] = y

Behaviour:
- Reset: state IDLE; active_o=0, ready_o=1, valid_o=0, mode_o=0; data registers as set by DATA_RST.
- A reset mid-operation aborts the job.
- Round count T per (WW,NKW): 16/4:32; 24/3:36; 24/4:36; 32/3:42; 32/4:44; 48/2:52; 48/3:54; 64/2:68; 64/3:69; 64/4:72.
- z-sequence index per (WW,NKW), in the same order: z0, z0, z1, z2, z3, z2, z3, z2, z3, z4. z constants are the published 62-bit sequences; bit index (i-m) mod 62.
- Round function: f(x) = (S1 x & S8 x) ^ S2 x, where Sj is rotate-left by j.
  - Encrypt round: x' = y ^ f(x) ^ k_i; y' = x.
  - Decrypt round: x' = y; y' = x ^ f(y) ^ k_i.
- Forward key schedule:
  - tmp = S^-3 k(i+m-1); if m=4, tmp ^= k(i+1).
  - tmp ^= S^-1 tmp.
  - k(i+m) = ~k(i) ^ tmp ^ z_bit ^ 3.
- Inverse key schedule: k(i) = ~(k(i+m) ^ tmp ^ z_bit ^ 3), with tmp computed from k(i+m-1) and k(i+1) exactly as in the forward schedule.
- FSM states: IDLE, ENC_RUN, KEY_EXP, DEC_LOAD, DEC_RUN, DONE.
  - ready_o = 1 only in IDLE. Handshake on edge E0 loads pt_i, key_i and mode, and clears the round counter (7 bits).
  - IDLE -> ENC_RUN if mode_i=0, else IDLE -> KEY_EXP.
  - ENC_RUN: one round per edge using k_i; advances the key window. After T rounds -> DONE, so valid_o rises T cycles after E0.
  - KEY_EXP: advances the key window only, for T-NKW steps. Captures the last NKW round keys k(T-NKW)..k(T-1) into the decrypt key store.
  - DEC_LOAD: 1 cycle; loads the key window from the store.
  - DEC_RUN: T inverse rounds using k(T-1) down to k0. Then -> DONE.
  - DONE: valid_o=1; ct_o and mode_o held stable until ready_i=1, then -> IDLE.
  - Back-to-back jobs: the next input is accepted no earlier than the cycle after the output handshake.
- Input rule: while valid_i & ~ready_o, the source holds valid_i, pt_i, key_i and mode_i stable (checked by assertion).
- Output rule: while valid_o & ~ready_i, valid_o, ct_o and mode_o stay stable.
- pt_i and key_i are sampled only at the handshake.
- ct_o keeps its last value after the output handshake, until the next job overwrites it.

Test Plan:
- Simon32/64 (WW16,NKW4) encrypt:
  - Stimulus: key_i[3..0] = 1918,1110,0908,0100; pt_i = {6565,6877}.
  - Required: ct_o = {c69b,e9bb}, mode_o=0, valid_o rises 32 cycles after the handshake.
- Simon32/64 decrypt: same key, pt_i = {c69b,e9bb}, mode 1 -> ct_o = {6565,6877}, mode_o=1.
- Simon64/128 (WW32,NKW4) encrypt:
  - Stimulus: key_i[3..0] = 1b1a1918,13121110,0b0a0908,03020100; pt_i = {656b696c,20646e75}.
  - Required: ct_o = {44c8fc20,b9dfa07a}. Decrypt of that value returns the plaintext.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> valid_o, ct_o and mode_o stable, ready_o=0, active_o=1. Raising ready_i gives IDLE next cycle with ready_o=1.
- Reset mid-run: assert arst_n low during ENC_RUN -> immediately valid_o=0, ready_o=1, active_o=0. The next job still produces correct results.
- Input stall: valid_i held high across the DONE state -> the second job is accepted only after the output handshake and yields the correct result.
